// File: rtl/sram_fifo_pkg.sv
// Packed-word layout shared by the AXI-to-FIFO packer and the read-side unpacker.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Word layout (LSB first): W[0] new beat, L[1] tlast of that beat, S[3:2] pack
// state, C[8:4] byte count - 1 of the beat completed here, P[200:9] payload.
package sram_fifo_pkg;

  localparam int PACKED_WIDTH = 201;
  localparam int BEAT_WIDTH   = 256;
  localparam int KEEP_WIDTH   = 32;

  localparam int W_BIT   = 0;
  localparam int L_BIT   = 1;
  localparam int S_LSB   = 2;
  localparam int S_WIDTH = 2;
  localparam int C_LSB   = 4;
  localparam int C_WIDTH = 5;
  localparam int P_LSB   = 9;
  localparam int P_WIDTH = 192;

  // Position of a word inside its group of four; also the unpacker's expected state.
  typedef enum logic [1:0] {
    PACK_S0 = 2'd0,
    PACK_S1 = 2'd1,
    PACK_S2 = 2'd2,
    PACK_S3 = 2'd3
  } pack_state_t;

  // Contiguous low-byte keep mask for a byte count of c+1 (c=31 gives all ones).
  function automatic logic [KEEP_WIDTH-1:0] keep_from_cnt(input logic [C_WIDTH-1:0] c);
    return {KEEP_WIDTH{1'b1}} >> (C_WIDTH'(KEEP_WIDTH - 1) - c);
  endfunction

endpackage

// File: rtl/sram_unpack_out_slice.sv
// One-entry AXI4-Stream output register for the unpacker.
// Latency: one clock from an accepted input to m_axis_tvalid.
// Backpressure: in_rdy = ~m_axis_tvalid | m_axis_tready; outputs hold while stalled.
//
// Ports: clk, resetn (async active-low); in_vld/in_rdy/in_dat/in_keep/in_last
// from the decoder; m_axis_tvalid/tready/tdata/tkeep/tlast to the stream master.
module sram_unpack_out_slice #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_dat,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast
);

  // The register may be refilled whenever it is empty or being drained this cycle.
  assign in_rdy = ~m_axis_tvalid | m_axis_tready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (in_rdy) begin
      m_axis_tvalid <= in_vld;
      if (in_vld) begin
        m_axis_tdata <= in_dat;
        m_axis_tkeep <= in_keep;
        m_axis_tlast <= in_last;
      end
    end
  end

endmodule

// File: rtl/sram_fifo_unpacker.sv
// Rebuilds 256-bit AXI4-Stream beats (tkeep, tlast) from 201-bit packed SRAM words.
// Latency: one clock from the accepted word that completes a beat to m_axis_tvalid.
// Backpressure: s_ready = ~m_axis_tvalid | m_axis_tready (low in and just after reset).
//
// Ports: clk, resetn (async active-low); s_valid/s_ready/s_data packed words in;
// m_axis_tvalid/tready/tdata/tkeep/tlast beats out; seq_err sticky sequence error;
// beat_cnt wrapping count of output handshakes.
// Optional: define SRAM_UNPACK_SEQ_CHECK_EN to check S against the expected state,
// flag seq_err and resynchronise on the next S=0/W=1 word.
module sram_fifo_unpacker #(
  parameter int TDATA_WIDTH  = 32,
  parameter int PACKED_WIDTH = sram_fifo_pkg::PACKED_WIDTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PACKED_WIDTH-1:0]  s_data,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [TDATA_WIDTH*8-1:0] m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     seq_err,
  output logic [31:0]              beat_cnt
);

  import sram_fifo_pkg::*;

  // Packed word fields
  logic               w_bit;
  logic               l_bit;
  logic [S_WIDTH-1:0] s_fld;
  logic [C_WIDTH-1:0] c_fld;
  logic [P_WIDTH-1:0] p_fld;

  assign w_bit = s_data[W_BIT];
  assign l_bit = s_data[L_BIT];
  assign s_fld = s_data[S_LSB +: S_WIDTH];
  assign c_fld = s_data[C_LSB +: C_WIDTH];
  assign p_fld = s_data[P_LSB +: P_WIDTH];

  // Decoder state: expected word position, partial beat, pending tlast.
  pack_state_t        e_q, e_d;
  logic [P_WIDTH-1:0] pr_q, pr_d;
  logic               pl_q, pl_d;

  logic                  out_of_rst;
  logic                  slice_rdy;
  logic                  acc;
  logic                  word_ok;
  logic                  force_idle;
  logic                  emit_vld;
  logic [BEAT_WIDTH-1:0] emit_dat;
  logic [KEEP_WIDTH-1:0] emit_keep;
  logic                  emit_last;

  // Hold s_ready low for the first clock after reset release as well as during reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_of_rst <= 1'b0;
    else         out_of_rst <= 1'b1;
  end

  // Non-emitting words are gated by the output slice too; keeps one acceptance rule.
  assign s_ready = out_of_rst & slice_rdy;
  assign acc     = s_valid & s_ready;

`ifdef SRAM_UNPACK_SEQ_CHECK_EN
  logic err_q, err_d;
  logic resync_q, resync_d;

  // A bad word sets the sticky error and sends the decoder idle; everything is then
  // discarded until a word that can legally open a group (S=0, W=1) shows up.
  always_comb begin
    err_d      = err_q;
    resync_d   = resync_q;
    word_ok    = 1'b0;
    force_idle = 1'b0;
    if (acc) begin
      if (resync_q) begin
        if (s_fld == PACK_S0 && w_bit) begin
          word_ok  = 1'b1;
          resync_d = 1'b0;
        end
      end else if (s_fld != e_q || (e_q == PACK_S0 && !w_bit)) begin
        err_d      = 1'b1;
        resync_d   = 1'b1;
        force_idle = 1'b1;
      end else begin
        word_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      resync_q <= resync_d;
    end
  end

  assign seq_err = err_q;
`else
  // S is not needed when the expected state alone drives decoding.
  logic unused_s_fld;
  assign unused_s_fld = ^s_fld;

  // A word with W=0 cannot start a beat, so at E=0 it is simply dropped.
  assign word_ok    = acc & ~(e_q == PACK_S0 & ~w_bit);
  assign force_idle = 1'b0;
  assign seq_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q  <= PACK_S0;
      pr_q <= '0;
      pl_q <= 1'b0;
    end else begin
      e_q  <= e_d;
      pr_q <= pr_d;
      pl_q <= pl_d;
    end
  end

  // Each emitting word completes the beat opened earlier: tlast comes from the
  // opening word (PL), tkeep from this word's C.
  always_comb begin
    e_d       = e_q;
    pr_d      = pr_q;
    pl_d      = pl_q;
    emit_vld  = 1'b0;
    emit_dat  = '0;
    emit_last = pl_q;
    emit_keep = keep_from_cnt(c_fld);
    if (force_idle) begin
      e_d = PACK_S0;
    end else if (word_ok) begin
      case (e_q)
        PACK_S0: begin
          if (w_bit) begin
            pr_d = p_fld;
            pl_d = l_bit;
            e_d  = PACK_S1;
          end
        end
        PACK_S1: begin
          emit_vld = 1'b1;
          emit_dat = {p_fld[63:0], pr_q[191:0]};
          if (w_bit) begin
            pr_d[127:0] = p_fld[191:64];
            pl_d        = l_bit;
            e_d         = PACK_S2;
          end else begin
            e_d = PACK_S0;
          end
        end
        PACK_S2: begin
          emit_vld = 1'b1;
          emit_dat = {p_fld[127:0], pr_q[127:0]};
          if (w_bit) begin
            pr_d[63:0] = p_fld[191:128];
            pl_d       = l_bit;
            e_d        = PACK_S3;
          end else begin
            e_d = PACK_S0;
          end
        end
        PACK_S3: begin
          // Last word of a group always closes it; W carries no meaning here.
          emit_vld = 1'b1;
          emit_dat = {p_fld[191:0], pr_q[63:0]};
          e_d      = PACK_S0;
        end
        default: e_d = PACK_S0;
      endcase
    end
  end

  sram_unpack_out_slice #(
    .DATA_W (TDATA_WIDTH * 8),
    .KEEP_W (TDATA_WIDTH)
  ) u_out_slice (
    .clk           (clk),
    .resetn        (resetn),
    .in_vld        (emit_vld),
    .in_rdy        (slice_rdy),
    .in_dat        (emit_dat),
    .in_keep       (emit_keep),
    .in_last       (emit_last),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            beat_cnt <= '0;
    else if (m_axis_tvalid && m_axis_tready) beat_cnt <= beat_cnt + 32'd1;
  end

endmodule

// File: doc/sram_fifo_unpacker.md
# sram_fifo_unpacker

Read-side stage of the SRAM FIFO datapath. Consumes the 201-bit packed words produced by the AXI-to-FIFO packer (four words carry three 256-bit beats, after they have been through SRAM and the read-side FIFO) and rebuilds the original AXI4-Stream beats with tkeep and tlast. Sits between the SRAM read FIFO and the output AXI4-Stream master port.

## Interface
- TDATA_WIDTH, 32: AXI data width in bytes (fixed 256-bit datapath; other values unsupported)
- PACKED_WIDTH, 201: packed word width
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- s_valid  in  1  packed word available
- s_ready  out  1  packed word accepted when s_valid && s_ready
- s_data  in  201  packed word
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  256  rebuilt beat
- m_axis_tkeep  out  32  contiguous low-byte keep
- m_axis_tlast  out  1  end of packet
- seq_err  out  1  sticky sequence error (only with check macro)
- beat_cnt  out  32  count of emitted beats, wraps

## Operation
- Word fields: [0] W (word introduces a new beat), [1] L (tlast of that new beat), [3:2] S (pack state 0..3), [8:4] C (byte count minus 1 of the beat completed by this word), [200:9] P (192-bit payload).
- Internal state: expected state E (0..3), partial register PR (192 b), pending last PL.
- E=0, W=1: PR[191:0]=P; PL=L; E=1; no emit.
- E=1, W=1: emit {P[63:0],PR[191:0]}, last=PL, keep from C; PR[127:0]=P[191:64]; PL=L; E=2.
- E=1, W=0 (flush): emit {P[63:0],PR[191:0]}, last=PL; E=0.
- E=2, W=1: emit {P[127:0],PR[127:0]}; PR[63:0]=P[191:128]; PL=L; E=3.
- E=2, W=0 (flush): emit {P[127:0],PR[127:0]}; E=0.
- E=3 (W ignored): emit {P[191:0],PR[63:0]}, last=PL; E=0.
- tkeep = (2^(C+1))-1 over 32 bits; C=31 gives all ones. Fields C, L of non-emitting words ignored except where listed.
- E=0 with W=0: protocol error; word dropped.
- Packet boundaries may occur mid-group (tlast beat followed directly by a W=1 word); treated as normal continuation.
- beat_cnt increments on each m_axis handshake.

## Timing
- Reset: m_axis_tvalid=0, tdata/tkeep/tlast=0, s_ready=0 during reset then 1, E=0, PR=0, PL=0, seq_err=0, beat_cnt=0.
- Single output register: s_ready = ~m_axis_tvalid | m_axis_tready. Words with no emit also gated by s_ready (simplicity).
- Latency: accepted word that emits drives m_axis_tvalid on next clock edge.
- Full throughput: accepted word every cycle when m_axis_tready=1; 3 beats per 4 words steady state.
- Output held stable while m_axis_tvalid && ~m_axis_tready.
- Reset mid-packet: partial beat discarded, E returns to 0.

## Configuration
- SRAM_UNPACK_SEQ_CHECK_EN defined: each accepted word's S compared to E; mismatch or E=0/W=0 sets seq_err (sticky until reset), drops word, forces E=0 and then discards words until one with S=0, W=1 arrives (resync).
- Undefined: S ignored, E alone drives decoding; E=0/W=0 word dropped silently; seq_err tied 0.

## Structure
- Package sram_fifo_pkg: field offsets/widths of packed word (W, L, S, C, P), pack-state constants, PACKED_WIDTH, shared with the packer.
- Sub-module sram_unpack_out_slice: one-entry AXI4-Stream output register with tvalid/tready hold logic.

## Test plan
- Three full beats, no backpressure, words S=0,1,2,3 all W=1 except S=3 -> three beats out, data matches, tkeep=0xFFFFFFFF, beat_cnt=3.
- Single-beat packet C=13, L=1, then flush word S=1, W=0 -> one beat, tkeep=0x00003FFF, tlast=1, E back to 0.
- Two-beat packet ending at E=2 flush -> second beat tlast=1; next word S=0 decodes correctly.
- Random m_axis_tready at 30% -> no loss/duplication, output stable while stalled, throughput restored when ready=1.
- With SRAM_UNPACK_SEQ_CHECK_EN: word S=2 when E=1 -> seq_err=1, words until S=0/W=1 dropped, next group decodes correctly.
- Assert resetn low after word S=1 -> all outputs zero, following S=0 group produces correct beats.
